// File: rtl/mano_datapath_io.sv
// Basic-computer data path with word memory, character I/O registers, FGI/FGO
// handshake flags and interrupt enable; every control input comes from the sequencer.
module mano_datapath_io #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int CHAR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        bus_select,
  input  logic              ar_load,
  input  logic              ar_inc,
  input  logic              ar_clr,
  input  logic              pc_load,
  input  logic              pc_inc,
  input  logic              pc_clr,
  input  logic              dr_load,
  input  logic              dr_inc,
  input  logic              dr_clr,
  input  logic              ac_load,
  input  logic              ac_inc,
  input  logic              ac_clr,
  input  logic              tr_load,
  input  logic              tr_inc,
  input  logic              tr_clr,
  input  logic              ir_load,
  input  logic              outr_load,
  input  logic              e_load,
  input  logic              e_clr,
  input  logic              e_cmp,
  input  logic [2:0]        alu_opcode,
  input  logic              mem_write,
  input  logic              fgi_clr,
  input  logic              ien_set,
  input  logic              ien_clr,
  input  logic              in_valid,
  input  logic [CHAR_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [CHAR_W-1:0] out_data,
  input  logic              out_ready,
  output logic [DATA_W-1:0] bus_out,
  output logic [ADDR_W-1:0] ar_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] dr_out,
  output logic [DATA_W-1:0] ac_out,
  output logic [DATA_W-1:0] ir_out,
  output logic [DATA_W-1:0] tr_out,
  output logic              e_out,
  output logic              ien_out,
  output logic              fgi_out,
  output logic              fgo_out,
  output logic              irq,
  output logic              ac_zero,
  output logic              dr_zero
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_LOAD = 3'd2;
  localparam logic [2:0] OP_INP  = 3'd3;
  localparam logic [2:0] OP_CMA  = 3'd4;
  localparam logic [2:0] OP_CIR  = 3'd5;
  localparam logic [2:0] OP_CIL  = 3'd6;

  localparam logic [DATA_W-1:0] CHAR_MASK = DATA_W'({CHAR_W{1'b1}});

  logic [ADDR_W-1:0] ar_reg, pc_reg;
  logic [DATA_W-1:0] dr_reg, ac_reg, ir_reg, tr_reg;
  logic [CHAR_W-1:0] inpr_reg, outr_reg;
  logic              e_reg, ien_reg, fgi_reg, fgo_reg;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] alu_out;
  logic              alu_e;
  logic [DATA_W:0]   sum;

  logic in_accept, out_done;

  assign mem_rdata = mem[ar_reg];

  // Common bus; address registers are zero-extended onto the word-wide bus
  always_comb begin
    bus_out = '0;
    case (bus_select)
      3'd1: bus_out = DATA_W'(ar_reg);
      3'd2: bus_out = DATA_W'(pc_reg);
      3'd3: bus_out = dr_reg;
      3'd4: bus_out = ac_reg;
      3'd5: bus_out = ir_reg;
      3'd6: bus_out = tr_reg;
      3'd7: bus_out = mem_rdata;
      default: bus_out = '0;
    endcase
  end

  assign sum = {1'b0, ac_reg} + {1'b0, dr_reg};

  // alu_e is only consumed by E for ADD/CIR/CIL; other opcodes leave E alone
  always_comb begin
    alu_out = ac_reg;
    alu_e   = e_reg;
    case (alu_opcode)
      OP_AND:  alu_out = ac_reg & dr_reg;
      OP_ADD:  begin
        alu_out = sum[DATA_W-1:0];
        alu_e   = sum[DATA_W];
      end
      OP_LOAD: alu_out = dr_reg;
      OP_INP:  alu_out = (ac_reg & ~CHAR_MASK) | DATA_W'(inpr_reg);
      OP_CMA:  alu_out = ~ac_reg;
      OP_CIR:  begin
        alu_out = {e_reg, ac_reg[DATA_W-1:1]};
        alu_e   = ac_reg[0];
      end
      OP_CIL:  begin
        alu_out = {ac_reg[DATA_W-2:0], e_reg};
        alu_e   = ac_reg[DATA_W-1];
      end
      default: alu_out = ac_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)          ar_reg <= '0;
    else if (ar_clr)  ar_reg <= '0;
    else if (ar_load) ar_reg <= bus_out[ADDR_W-1:0];
    else if (ar_inc)  ar_reg <= ar_reg + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)          pc_reg <= '0;
    else if (pc_clr)  pc_reg <= '0;
    else if (pc_load) pc_reg <= bus_out[ADDR_W-1:0];
    else if (pc_inc)  pc_reg <= pc_reg + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)          dr_reg <= '0;
    else if (dr_clr)  dr_reg <= '0;
    else if (dr_load) dr_reg <= bus_out;
    else if (dr_inc)  dr_reg <= dr_reg + DATA_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)          ac_reg <= '0;
    else if (ac_clr)  ac_reg <= '0;
    else if (ac_load) ac_reg <= alu_out;
    else if (ac_inc)  ac_reg <= ac_reg + DATA_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)          tr_reg <= '0;
    else if (tr_clr)  tr_reg <= '0;
    else if (tr_load) tr_reg <= bus_out;
    else if (tr_inc)  tr_reg <= tr_reg + DATA_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_reg   <= '0;
      outr_reg <= '0;
    end else begin
      if (ir_load)   ir_reg   <= bus_out;
      if (outr_load) outr_reg <= bus_out[CHAR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         e_reg <= 1'b0;
    else if (e_clr)  e_reg <= 1'b0;
    else if (e_load) begin
      if (alu_opcode == OP_ADD || alu_opcode == OP_CIR || alu_opcode == OP_CIL)
        e_reg <= alu_e;
    end
    else if (e_cmp)  e_reg <= ~e_reg;
  end

  // Reading and writing M[AR] in one cycle rewrites the word it already holds
  always_ff @(posedge clk) begin
    if (mem_write) mem[ar_reg] <= bus_out;
  end

  assign in_accept = in_valid & in_ready;
  assign out_done  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      inpr_reg <= '0;
      fgi_reg  <= 1'b0;
    end else if (in_accept) begin
      inpr_reg <= in_data;
      fgi_reg  <= 1'b1;
    end else if (fgi_clr) begin
      fgi_reg  <= 1'b0;
    end
  end

  // A fresh OUTR load re-arms the device even if the old character completes now
  always_ff @(posedge clk) begin
    if (rst)            fgo_reg <= 1'b1;
    else if (outr_load) fgo_reg <= 1'b0;
    else if (out_done)  fgo_reg <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)          ien_reg <= 1'b0;
    else if (ien_clr) ien_reg <= 1'b0;
    else if (ien_set) ien_reg <= 1'b1;
  end

  assign in_ready  = ~fgi_reg;
  assign out_valid = ~fgo_reg;
  assign out_data  = outr_reg;

  assign ar_out  = ar_reg;
  assign pc_out  = pc_reg;
  assign dr_out  = dr_reg;
  assign ac_out  = ac_reg;
  assign ir_out  = ir_reg;
  assign tr_out  = tr_reg;
  assign e_out   = e_reg;
  assign ien_out = ien_reg;
  assign fgi_out = fgi_reg;
  assign fgo_out = fgo_reg;

  assign irq     = ien_reg & (fgi_reg | fgo_reg);
  assign ac_zero = (ac_reg == '0);
  assign dr_zero = (dr_reg == '0);

endmodule

// File: tb/tb_mano_datapath_io.sv
// Directed-vector bench for mano_datapath_io; each scenario task checks its own results.
module tb_mano_datapath_io;

  logic        clk, rst;
  logic [2:0]  bus_select, alu_opcode;
  logic        ar_load, ar_inc, ar_clr, pc_load, pc_inc, pc_clr;
  logic        dr_load, dr_inc, dr_clr, ac_load, ac_inc, ac_clr;
  logic        tr_load, tr_inc, tr_clr, ir_load, outr_load;
  logic        e_load, e_clr, e_cmp, mem_write, fgi_clr, ien_set, ien_clr;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data, out_data;
  logic [15:0] bus_out, dr_out, ac_out, ir_out, tr_out;
  logic [11:0] ar_out, pc_out;
  logic        e_out, ien_out, fgi_out, fgo_out, irq, ac_zero, dr_zero;

  int vectors = 0;
  int miscompares = 0;

  mano_datapath_io dut (
    .clk(clk), .rst(rst), .bus_select(bus_select),
    .ar_load(ar_load), .ar_inc(ar_inc), .ar_clr(ar_clr),
    .pc_load(pc_load), .pc_inc(pc_inc), .pc_clr(pc_clr),
    .dr_load(dr_load), .dr_inc(dr_inc), .dr_clr(dr_clr),
    .ac_load(ac_load), .ac_inc(ac_inc), .ac_clr(ac_clr),
    .tr_load(tr_load), .tr_inc(tr_inc), .tr_clr(tr_clr),
    .ir_load(ir_load), .outr_load(outr_load),
    .e_load(e_load), .e_clr(e_clr), .e_cmp(e_cmp),
    .alu_opcode(alu_opcode), .mem_write(mem_write),
    .fgi_clr(fgi_clr), .ien_set(ien_set), .ien_clr(ien_clr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .bus_out(bus_out), .ar_out(ar_out), .pc_out(pc_out),
    .dr_out(dr_out), .ac_out(ac_out), .ir_out(ir_out), .tr_out(tr_out),
    .e_out(e_out), .ien_out(ien_out), .fgi_out(fgi_out), .fgo_out(fgo_out),
    .irq(irq), .ac_zero(ac_zero), .dr_zero(dr_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus_select = 3'd0; alu_opcode = 3'd7;
    ar_load = 0; ar_inc = 0; ar_clr = 0; pc_load = 0; pc_inc = 0; pc_clr = 0;
    dr_load = 0; dr_inc = 0; dr_clr = 0; ac_load = 0; ac_inc = 0; ac_clr = 0;
    tr_load = 0; tr_inc = 0; tr_clr = 0; ir_load = 0; outr_load = 0;
    e_load = 0; e_clr = 0; e_cmp = 0; mem_write = 0;
    fgi_clr = 0; ien_set = 0; ien_clr = 0; in_valid = 0; in_data = 8'h00;
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Accept a character, merge it into AC's low byte, then release FGI
  task automatic put_char(input logic [7:0] c);
    in_valid = 1; in_data = c;
    step();
    alu_opcode = 3'd3; ac_load = 1;
    step();
    fgi_clr = 1;
    step();
  endtask

  task automatic shift8();
    e_clr = 1;
    step();
    for (int i = 0; i < 8; i++) begin
      alu_opcode = 3'd6; ac_load = 1; e_load = 1;
      step();
    end
  endtask

  task automatic test_reset();
    idle(); out_ready = 0; rst = 1;
    step(); step();
    rst = 0;
    vectors++; if (ac_out !== 16'h0000) begin $display("FAIL reset_ac got %h want 0000", ac_out); miscompares++; end
    vectors++; if (ar_out !== 12'h000) begin $display("FAIL reset_ar got %h want 000", ar_out); miscompares++; end
    vectors++; if (e_out !== 1'b0) begin $display("FAIL reset_e got %b want 0", e_out); miscompares++; end
    vectors++; if ({fgi_out, fgo_out, ien_out} !== 3'b010) begin $display("FAIL reset_flags got %b want 010", {fgi_out, fgo_out, ien_out}); miscompares++; end
    vectors++; if ({in_ready, out_valid, irq} !== 3'b100) begin $display("FAIL reset_status got %b want 100", {in_ready, out_valid, irq}); miscompares++; end
    $display("test_reset done");
  endtask

  task automatic test_add();
    alu_opcode = 3'd4; ac_load = 1;
    step();
    vectors++; if (ac_out !== 16'hFFFF) begin $display("FAIL cma got %h want FFFF", ac_out); miscompares++; end
    bus_select = 3'd4; dr_load = 1;
    step();
    vectors++; if (dr_out !== 16'hFFFF) begin $display("FAIL dr_load got %h want FFFF", dr_out); miscompares++; end
    ac_inc = 1;
    step();
    vectors++; if (ac_out !== 16'h0000) begin $display("FAIL ac_inc_wrap got %h want 0000", ac_out); miscompares++; end
    ac_inc = 1;
    step();
    alu_opcode = 3'd1; ac_load = 1; e_load = 1;
    step();
    vectors++; if (ac_out !== 16'h0000) begin $display("FAIL add_ac got %h want 0000", ac_out); miscompares++; end
    vectors++; if (e_out !== 1'b1) begin $display("FAIL add_e got %b want 1", e_out); miscompares++; end
    vectors++; if ({ac_zero, dr_zero} !== 2'b10) begin $display("FAIL add_zero got %b want 10", {ac_zero, dr_zero}); miscompares++; end
    $display("test_add done");
  endtask

  task automatic test_rotate();
    ac_inc = 1;
    step();
    alu_opcode = 3'd5; ac_load = 1; e_load = 1;
    step();
    vectors++; if ({e_out, ac_out} !== 17'h1_8000) begin $display("FAIL cir_build got %h want 18000", {e_out, ac_out}); miscompares++; end
    ac_inc = 1;
    step();
    e_clr = 1;
    step();
    alu_opcode = 3'd6; ac_load = 1; e_load = 1;
    step();
    vectors++; if ({e_out, ac_out} !== 17'h1_0002) begin $display("FAIL cil got %h want 10002", {e_out, ac_out}); miscompares++; end
    alu_opcode = 3'd5; ac_load = 1; e_load = 1;
    step();
    vectors++; if ({e_out, ac_out} !== 17'h0_8001) begin $display("FAIL cir got %h want 08001", {e_out, ac_out}); miscompares++; end
    e_cmp = 1;
    step();
    vectors++; if (e_out !== 1'b1) begin $display("FAIL e_cmp got %b want 1", e_out); miscompares++; end
    alu_opcode = 3'd0; e_load = 1;
    step();
    vectors++; if (e_out !== 1'b1) begin $display("FAIL e_hold got %b want 1", e_out); miscompares++; end
    $display("test_rotate done");
  endtask

  task automatic test_memory();
    ac_clr = 1;
    step();
    alu_opcode = 3'd4; ac_load = 1;
    step();
    bus_select = 3'd4; ar_load = 1;
    step();
    vectors++; if (ar_out !== 12'hFFF) begin $display("FAIL ar_load got %h want FFF", ar_out); miscompares++; end
    ac_clr = 1;
    step();
    put_char(8'hBE);
    shift8();
    put_char(8'hEF);
    vectors++; if (ac_out !== 16'hBEEF) begin $display("FAIL build_beef got %h want BEEF", ac_out); miscompares++; end
    bus_select = 3'd4; mem_write = 1;
    step();
    bus_select = 3'd7; mem_write = 1;
    step();
    bus_select = 3'd7; dr_load = 1;
    #1;
    vectors++; if (bus_out !== 16'hBEEF) begin $display("FAIL mem_bus got %h want BEEF", bus_out); miscompares++; end
    step();
    vectors++; if (dr_out !== 16'hBEEF) begin $display("FAIL mem_dr got %h want BEEF", dr_out); miscompares++; end
    ar_inc = 1;
    step();
    vectors++; if (ar_out !== 12'h000) begin $display("FAIL ar_wrap got %h want 000", ar_out); miscompares++; end
    bus_select = 3'd4; pc_load = 1;
    step();
    vectors++; if (pc_out !== 12'hEEF) begin $display("FAIL pc_load got %h want EEF", pc_out); miscompares++; end
    pc_inc = 1;
    step();
    vectors++; if (pc_out !== 12'hEF0) begin $display("FAIL pc_inc got %h want EF0", pc_out); miscompares++; end
    bus_select = 3'd3; tr_load = 1; ir_load = 1;
    step();
    vectors++; if (ir_out !== 16'hBEEF) begin $display("FAIL ir_load got %h want BEEF", ir_out); miscompares++; end
    tr_inc = 1;
    step();
    bus_select = 3'd6;
    #1;
    vectors++; if (bus_out !== 16'hBEF0) begin $display("FAIL tr_bus got %h want BEF0", bus_out); miscompares++; end
    bus_select = 3'd2;
    #1;
    vectors++; if (bus_out !== 16'h0EF0) begin $display("FAIL pc_bus got %h want 0EF0", bus_out); miscompares++; end
    step();
    $display("test_memory done");
  endtask

  task automatic test_input();
    ac_clr = 1;
    step();
    put_char(8'h12);
    shift8();
    vectors++; if (ac_out !== 16'h1200) begin $display("FAIL build_1200 got %h want 1200", ac_out); miscompares++; end
    in_valid = 1; in_data = 8'h41;
    step();
    vectors++; if ({fgi_out, in_ready} !== 2'b10) begin $display("FAIL accept got %b want 10", {fgi_out, in_ready}); miscompares++; end
    in_valid = 1; in_data = 8'h77; alu_opcode = 3'd3; ac_load = 1;
    step();
    vectors++; if (ac_out !== 16'h1241) begin $display("FAIL inp got %h want 1241", ac_out); miscompares++; end
    in_valid = 1; in_data = 8'h77; fgi_clr = 1;
    step();
    vectors++; if ({fgi_out, in_ready} !== 2'b01) begin $display("FAIL fgi_clr got %b want 01", {fgi_out, in_ready}); miscompares++; end
    in_valid = 1; in_data = 8'h77;
    step();
    vectors++; if (fgi_out !== 1'b1) begin $display("FAIL second_accept got %b want 1", fgi_out); miscompares++; end
    alu_opcode = 3'd3; ac_load = 1;
    step();
    vectors++; if (ac_out !== 16'h1277) begin $display("FAIL second_inp got %h want 1277", ac_out); miscompares++; end
    fgi_clr = 1;
    step();
    $display("test_input done");
  endtask

  task automatic test_output();
    ac_clr = 1;
    step();
    put_char(8'h5A);
    out_ready = 0; bus_select = 3'd4; outr_load = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      vectors++; if ({out_valid, fgo_out, out_data} !== {2'b10, 8'h5A}) begin $display("FAIL out_hold%0d got %b_%h want 10_5A", i, {out_valid, fgo_out}, out_data); miscompares++; end
      step();
    end
    out_ready = 1;
    step();
    vectors++; if ({fgo_out, out_valid} !== 2'b10) begin $display("FAIL out_done got %b want 10", {fgo_out, out_valid}); miscompares++; end
    out_ready = 0; bus_select = 3'd4; outr_load = 1;
    step();
    out_ready = 1; bus_select = 3'd4; outr_load = 1;
    step();
    vectors++; if (fgo_out !== 1'b0) begin $display("FAIL outr_override got %b want 0", fgo_out); miscompares++; end
    step();
    vectors++; if (fgo_out !== 1'b1) begin $display("FAIL out_done2 got %b want 1", fgo_out); miscompares++; end
    out_ready = 0;
    $display("test_output done");
  endtask

  task automatic test_priority();
    ien_set = 1;
    step();
    vectors++; if ({ien_out, irq} !== 2'b11) begin $display("FAIL ien_irq got %b want 11", {ien_out, irq}); miscompares++; end
    ien_set = 1; ien_clr = 1;
    step();
    vectors++; if ({ien_out, irq} !== 2'b00) begin $display("FAIL ien_prio got %b want 00", {ien_out, irq}); miscompares++; end
    alu_opcode = 3'd7; ac_clr = 1; ac_load = 1; ac_inc = 1;
    step();
    vectors++; if (ac_out !== 16'h0000) begin $display("FAIL ac_prio got %h want 0000", ac_out); miscompares++; end
    ar_inc = 1;
    step();
    bus_select = 3'd0; ar_load = 1; ar_inc = 1;
    step();
    vectors++; if (ar_out !== 12'h000) begin $display("FAIL ar_prio got %h want 000", ar_out); miscompares++; end
    rst = 1; in_valid = 1; in_data = 8'h99;
    step();
    rst = 0;
    vectors++; if ({fgi_out, in_ready, fgo_out} !== 3'b011) begin $display("FAIL rst_input got %b want 011", {fgi_out, in_ready, fgo_out}); miscompares++; end
    alu_opcode = 3'd3; ac_load = 1;
    step();
    vectors++; if (ac_out !== 16'h0000) begin $display("FAIL rst_inpr got %h want 0000", ac_out); miscompares++; end
    $display("test_priority done");
  endtask

  initial begin
    rst = 1; out_ready = 0;
    idle();
    test_reset();
    test_add();
    test_rotate();
    test_memory();
    test_input();
    test_output();
    test_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
